// File: rtl/spw_cfg_pkg.sv
// Shared encodings for the SpaceWire-style configuration packet controller:
// command/reply codes, N-char control encodings and the parser state enum.
package spw_cfg_pkg;

    localparam logic [7:0] CMD_WRITE  = 8'h01;
    localparam logic [7:0] CMD_READ   = 8'h02;
    localparam logic [7:0] REPLY_CODE = 8'h82;

    localparam logic [8:0] EOP_CHAR = 9'h100;
    localparam logic [8:0] EEP_CHAR = 9'h101;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ADDR    = 3'd1,
        ST_DATA    = 3'd2,
        ST_TAIL    = 3'd3,
        ST_EXEC    = 3'd4,
        ST_REPLY   = 3'd5,
        ST_DISCARD = 3'd6
    } cfg_state_e;

    // Error counter increment that sticks at 255 instead of wrapping.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        if (v == 8'hFF) begin
            return v;
        end else begin
            return v + 8'd1;
        end
    endfunction

endpackage

// File: rtl/cfg_regfile.sv
// Configuration register array: one synchronous write port and two
// combinational read ports (user read-back and reply capture).
module cfg_regfile #(
    parameter int DW   = 32,
    parameter int NREG = 16,
    parameter int IW   = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we_i,
    input  logic [IW-1:0] widx_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [IW-1:0] ridx_a_i,
    output logic [DW-1:0] rdata_a_o,
    input  logic [IW-1:0] ridx_b_i,
    output logic [DW-1:0] rdata_b_o
);

    logic [DW-1:0] mem_q [NREG];

    // Register storage with synchronous clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                mem_q[i] <= {DW{1'b0}};
            end
        end else if (we_i) begin
            mem_q[widx_i] <= wdata_i;
        end
    end

    assign rdata_a_o = mem_q[ridx_a_i];
    assign rdata_b_o = mem_q[ridx_b_i];

endmodule

// File: rtl/cfg_pkt_ctrl.sv
// Packet-driven configuration controller: parses write/read command packets
// from an inbound N-char FIFO, updates the register file and emits read replies.
module cfg_pkt_ctrl
    import spw_cfg_pkg::*;
#(
    parameter int DW   = 32,
    parameter int AW   = 32,
    parameter int NREG = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          rx_empty_i,
    input  logic [8:0]    rx_data_i,
    output logic          rx_rd_o,
    input  logic          tx_full_i,
    output logic [8:0]    tx_data_o,
    output logic          tx_wr_o,
    output logic [DW-1:0] cfg_data_o,
    output logic          cfg_int_o,
    output logic          cfg_wrbusy_o,
    output logic [AW-1:0] cfg_int_addr,
    input  logic [AW-1:0] cfg_addr_i,
    output logic [7:0]    err_cnt_o
);

    localparam int AB = AW / 8;
    localparam int NB = DW / 8;
    localparam int IW = $clog2(NREG);

    cfg_state_e    state_q;
    logic          is_wr_q;
    logic          wrbusy_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [DW-1:0] shift_q;
    logic [8:0]    tx_data_q;
    logic [7:0]    cnt_q;
    logic [7:0]    err_q;
    logic          int_q;
    logic [AW-1:0] int_addr_q;

    logic          accept_s;
    logic          fire_s;
    logic          ctrl_s;
    logic          eep_s;
    logic [7:0]    byte_s;
    logic          addr_ok_s;
    logic          we_s;
    logic [7:0]    err_d;
    logic [DW-1:0] rd_a_s;
    logic [DW-1:0] rd_b_s;

    assign accept_s  = (state_q == ST_IDLE) || (state_q == ST_ADDR) || (state_q == ST_DATA) ||
                       (state_q == ST_TAIL) || (state_q == ST_DISCARD);
    // Gated by rst_n so no character is popped and lost while in reset.
    assign fire_s    = rst_n && accept_s && !rx_empty_i;
    assign ctrl_s    = rx_data_i[8];
    assign eep_s     = rx_data_i[8] && rx_data_i[0];
    assign byte_s    = rx_data_i[7:0];
    assign addr_ok_s = ((addr_q >> IW) == {AW{1'b0}});
    assign we_s      = (state_q == ST_EXEC) && is_wr_q && addr_ok_s;
    assign err_d     = sat_inc8(err_q);

    cfg_regfile #(
        .DW   (DW),
        .NREG (NREG),
        .IW   (IW)
    ) u_regfile (
        .clk       (clk),
        .rst_n     (rst_n),
        .we_i      (we_s),
        .widx_i    (addr_q[IW-1:0]),
        .wdata_i   (wdata_q),
        .ridx_a_i  (cfg_addr_i[IW-1:0]),
        .rdata_a_o (rd_a_s),
        .ridx_b_i  (addr_q[IW-1:0]),
        .rdata_b_o (rd_b_s)
    );

    // User read-back; addresses outside the register window read as zero.
    always_comb begin
        cfg_data_o = {DW{1'b0}};
        if ((cfg_addr_i >> IW) == {AW{1'b0}}) begin
            cfg_data_o = rd_a_s;
        end else begin
            cfg_data_o = {DW{1'b0}};
        end
    end

    // Packet parser, command execution and reply sequencer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            is_wr_q    <= 1'b0;
            wrbusy_q   <= 1'b0;
            addr_q     <= {AW{1'b0}};
            wdata_q    <= {DW{1'b0}};
            shift_q    <= {DW{1'b0}};
            tx_data_q  <= 9'h000;
            cnt_q      <= 8'd0;
            err_q      <= 8'd0;
            int_q      <= 1'b0;
            int_addr_q <= {AW{1'b0}};
        end else begin
            int_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (fire_s && !ctrl_s) begin
                        if ((byte_s == CMD_WRITE) || (byte_s == CMD_READ)) begin
                            is_wr_q  <= (byte_s == CMD_WRITE);
                            wrbusy_q <= (byte_s == CMD_WRITE);
                            addr_q   <= {AW{1'b0}};
                            cnt_q    <= 8'd0;
                            state_q  <= ST_ADDR;
                        end else begin
                            state_q <= ST_DISCARD;
                        end
                    end
                end
                ST_ADDR: begin
                    if (fire_s) begin
                        if (ctrl_s) begin
                            err_q    <= err_d;
                            wrbusy_q <= 1'b0;
                            state_q  <= ST_IDLE;
                        end else begin
                            addr_q <= (addr_q << 8) | AW'(byte_s);
                            if (cnt_q == 8'(AB - 1)) begin
                                cnt_q   <= 8'd0;
                                state_q <= is_wr_q ? ST_DATA : ST_TAIL;
                            end else begin
                                cnt_q <= cnt_q + 8'd1;
                            end
                        end
                    end
                end
                ST_DATA: begin
                    if (fire_s) begin
                        if (ctrl_s) begin
                            err_q    <= err_d;
                            wrbusy_q <= 1'b0;
                            state_q  <= ST_IDLE;
                        end else begin
                            wdata_q <= (wdata_q << 8) | DW'(byte_s);
                            if (cnt_q == 8'(NB - 1)) begin
                                cnt_q   <= 8'd0;
                                state_q <= ST_TAIL;
                            end else begin
                                cnt_q <= cnt_q + 8'd1;
                            end
                        end
                    end
                end
                ST_TAIL: begin
                    if (fire_s) begin
                        if (ctrl_s && !eep_s) begin
                            state_q <= ST_EXEC;
                        end else if (ctrl_s) begin
                            err_q    <= err_d;
                            wrbusy_q <= 1'b0;
                            state_q  <= ST_IDLE;
                        end else begin
                            wrbusy_q <= 1'b0;
                            state_q  <= ST_DISCARD;
                        end
                    end
                end
                ST_EXEC: begin
                    wrbusy_q <= 1'b0;
                    if (!addr_ok_s) begin
                        err_q   <= err_d;
                        state_q <= ST_IDLE;
                    end else if (is_wr_q) begin
                        int_q      <= 1'b1;
                        int_addr_q <= addr_q;
                        state_q    <= ST_IDLE;
                    end else begin
                        shift_q   <= rd_b_s;
                        tx_data_q <= {1'b0, REPLY_CODE};
                        cnt_q     <= 8'd0;
                        state_q   <= ST_REPLY;
                    end
                end
                ST_REPLY: begin
                    // cnt_q = number of characters already pushed; advance only on a push.
                    if (!tx_full_i) begin
                        if (cnt_q == 8'(NB + 1)) begin
                            state_q <= ST_IDLE;
                        end else if (cnt_q == 8'(NB)) begin
                            tx_data_q <= EOP_CHAR;
                            cnt_q     <= cnt_q + 8'd1;
                        end else begin
                            tx_data_q <= {1'b0, shift_q[DW-1 -: 8]};
                            shift_q   <= shift_q << 8;
                            cnt_q     <= cnt_q + 8'd1;
                        end
                    end
                end
                ST_DISCARD: begin
                    if (fire_s && ctrl_s) begin
                        err_q   <= err_d;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign rx_rd_o      = fire_s;
    assign tx_wr_o      = rst_n && (state_q == ST_REPLY) && !tx_full_i;
    assign tx_data_o    = tx_data_q;
    assign cfg_int_o    = int_q;
    assign cfg_wrbusy_o = wrbusy_q;
    assign cfg_int_addr = int_addr_q;
    assign err_cnt_o    = err_q;

endmodule

// File: tb/tb_cfg_pkt_ctrl.sv
// Self-checking bench: FIFO-fed packet stream against a packet-level model
// of register contents, error count, interrupts and expected reply characters.
module tb_cfg_pkt_ctrl;

    localparam int DW   = 32;
    localparam int AW   = 32;
    localparam int NREG = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          rx_empty_i;
    logic [8:0]    rx_data_i;
    logic          rx_rd_o;
    logic          tx_full_i;
    logic [8:0]    tx_data_o;
    logic          tx_wr_o;
    logic [DW-1:0] cfg_data_o;
    logic          cfg_int_o;
    logic          cfg_wrbusy_o;
    logic [AW-1:0] cfg_int_addr;
    logic [AW-1:0] cfg_addr_i;
    logic [7:0]    err_cnt_o;

    always #5 clk = ~clk;

    cfg_pkt_ctrl #(.DW(DW), .AW(AW), .NREG(NREG)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx_empty_i   (rx_empty_i),
        .rx_data_i    (rx_data_i),
        .rx_rd_o      (rx_rd_o),
        .tx_full_i    (tx_full_i),
        .tx_data_o    (tx_data_o),
        .tx_wr_o      (tx_wr_o),
        .cfg_data_o   (cfg_data_o),
        .cfg_int_o    (cfg_int_o),
        .cfg_wrbusy_o (cfg_wrbusy_o),
        .cfg_int_addr (cfg_int_addr),
        .cfg_addr_i   (cfg_addr_i),
        .err_cnt_o    (err_cnt_o)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [DW-1:0] mem_m [NREG];
    int            err_m;
    int            int_m;
    logic [AW-1:0] last_addr_m;
    logic [8:0]    rx_q[$];
    logic [8:0]    tx_exp[$];
    logic [8:0]    tx_got[$];

    // Monitor state
    int            int_seen;
    int            full_mode;
    logic          rst_drv;
    bit            bad_rd;
    bit            bad_early;
    bit            wrbusy_seen;
    bit            watch_en;
    logic [DW-1:0] prev_cfg;
    logic          last_tx_wr;

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push_word(input logic [63:0] w, input int nbytes);
        for (int i = nbytes - 1; i >= 0; i--) rx_q.push_back({1'b0, w[8*i +: 8]});
    endtask

    function automatic bit in_range(input logic [AW-1:0] a);
        return (a < AW'(NREG));
    endfunction

    task automatic pkt_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        push_word(64'h01, 1);
        push_word(64'(a), AW / 8);
        push_word(64'(d), DW / 8);
        rx_q.push_back(9'h100);
        if (in_range(a)) begin
            mem_m[a] = d;
            int_m++;
            last_addr_m = a;
        end else begin
            err_m++;
        end
    endtask

    task automatic pkt_read(input logic [AW-1:0] a);
        push_word(64'h02, 1);
        push_word(64'(a), AW / 8);
        rx_q.push_back(9'h100);
        if (in_range(a)) begin
            tx_exp.push_back(9'h082);
            for (int i = DW / 8 - 1; i >= 0; i--) tx_exp.push_back({1'b0, mem_m[a][8*i +: 8]});
            tx_exp.push_back(9'h100);
        end else begin
            err_m++;
        end
    endtask

    // Write packet cut after 'cut' address/data bytes (1..7) by EOP or EEP.
    task automatic pkt_trunc(input logic [AW-1:0] a, input logic [DW-1:0] d, input int cut, input bit eep);
        logic [63:0] ad;
        ad = {a, d};
        push_word(64'h01, 1);
        for (int i = 0; i < cut; i++) rx_q.push_back({1'b0, ad[63 - 8*i -: 8]});
        rx_q.push_back(eep ? 9'h101 : 9'h100);
        err_m++;
    endtask

    task automatic pkt_badcmd(input logic [7:0] cmd, input int n);
        push_word(64'(cmd), 1);
        for (int i = 0; i < n; i++) push_word(64'($urandom_range(0, 255)), 1);
        rx_q.push_back(($urandom_range(0, 1) == 1) ? 9'h101 : 9'h100);
        err_m++;
    endtask

    // Complete write followed by either a stray data byte or EEP instead of EOP.
    task automatic pkt_badtail(input logic [AW-1:0] a, input logic [DW-1:0] d, input bit eep);
        push_word(64'h01, 1);
        push_word(64'(a), AW / 8);
        push_word(64'(d), DW / 8);
        if (eep) begin
            rx_q.push_back(9'h101);
        end else begin
            push_word(64'h5A, 1);
            rx_q.push_back(9'h100);
        end
        err_m++;
    endtask

    // One clock: drive FIFO heads on the falling edge, then record what the DUT will do.
    task automatic step();
        @(negedge clk);
        rst_n      = rst_drv;
        rx_empty_i = (rx_q.size() == 0);
        rx_data_i  = rx_empty_i ? 9'h000 : rx_q[0];
        case (full_mode)
            1:       tx_full_i = ~tx_full_i;
            2:       tx_full_i = ($urandom_range(0, 2) == 0);
            default: tx_full_i = 1'b0;
        endcase
        #1;
        if (rx_rd_o) begin
            if (rx_empty_i) bad_rd = 1'b1;
            else void'(rx_q.pop_front());
        end
        last_tx_wr = tx_wr_o;
        if (tx_wr_o) tx_got.push_back(tx_data_o);
        if (cfg_int_o) int_seen++;
        if (cfg_wrbusy_o) wrbusy_seen = 1'b1;
        if (watch_en && (cfg_data_o !== prev_cfg) && !cfg_int_o) bad_early = 1'b1;
        prev_cfg = cfg_data_o;
    endtask

    task automatic drain(input string tag);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 4000 && !done; i++) begin
            step();
            if (rx_q.size() == 0 && tx_got.size() >= tx_exp.size()) done = 1'b1;
        end
        for (int i = 0; i < 8; i++) step();
        chk_eq({tag, "_drain_done"}, 64'(done), 64'd1);
    endtask

    task automatic verify(input string tag);
        int n;
        n = (tx_got.size() < tx_exp.size()) ? tx_got.size() : tx_exp.size();
        chk_eq({tag, "_tx_count"}, 64'(tx_got.size()), 64'(tx_exp.size()));
        for (int i = 0; i < n; i++) chk_eq({tag, "_tx_char"}, 64'(tx_got[i]), 64'(tx_exp[i]));
        tx_got.delete();
        tx_exp.delete();
        chk_eq({tag, "_err_cnt"}, 64'(err_cnt_o), 64'((err_m > 255) ? 255 : err_m));
        chk_eq({tag, "_int_pulses"}, 64'(int_seen), 64'(int_m));
        chk_eq({tag, "_int_addr"}, 64'(cfg_int_addr), 64'(last_addr_m));
        chk_eq({tag, "_wrbusy_idle"}, 64'(cfg_wrbusy_o), 64'd0);
        chk_eq({tag, "_no_rd_when_empty"}, 64'(bad_rd), 64'd0);
        watch_en = 1'b0;
        for (int k = 0; k < NREG; k++) begin
            @(negedge clk);
            cfg_addr_i = AW'(k);
            #1;
            chk_eq({tag, "_reg"}, 64'(cfg_data_o), 64'(mem_m[k]));
        end
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int_seen = 0; int_m = 0; err_m = 0; last_addr_m = '0;
        full_mode = 0; bad_rd = 1'b0; bad_early = 1'b0; wrbusy_seen = 1'b0;
        watch_en = 1'b0; prev_cfg = '0; last_tx_wr = 1'b0;
        for (int k = 0; k < NREG; k++) mem_m[k] = '0;
        rst_drv = 1'b0; rst_n = 1'b0; rx_empty_i = 1'b1; rx_data_i = 9'h000;
        tx_full_i = 1'b0; cfg_addr_i = '0;

        // Reset state; a pending character must not be popped while in reset.
        rx_q.push_back(9'h001);
        repeat (3) step();
        chk_eq("rst_not_popped", 64'(rx_q.size()), 64'd1);
        chk_eq("rst_err_cnt", 64'(err_cnt_o), 64'd0);
        chk_eq("rst_tx_data", 64'(tx_data_o), 64'd0);
        chk_eq("rst_int", 64'(cfg_int_o), 64'd0);
        chk_eq("rst_wrbusy", 64'(cfg_wrbusy_o), 64'd0);
        chk_eq("rst_int_addr", 64'(cfg_int_addr), 64'd0);
        chk_eq("rst_tx_wr", 64'(last_tx_wr), 64'd0);
        rx_q.delete();
        rst_drv = 1'b1;
        step();

        // Basic write; read-back of reg3 may change only with the commit.
        cfg_addr_i = 32'd3;
        step();
        watch_en = 1'b1;
        pkt_write(32'd3, 32'hDEADBEEF);
        drain("wr3");
        chk_eq("wr3_old_until_commit", 64'(bad_early), 64'd0);
        chk_eq("wr3_wrbusy_seen", 64'(wrbusy_seen), 64'd1);
        chk_eq("wr3_one_pulse", 64'(int_seen), 64'd1);
        verify("wr3");

        // Read reply under a toggling full flag.
        full_mode = 1;
        pkt_read(32'd3);
        drain("rd3");
        verify("rd3");
        full_mode = 0;

        // Write truncated by EEP after two data bytes, then a normal write.
        pkt_trunc(32'd5, 32'h11223344, 6, 1'b1);
        pkt_write(32'd5, 32'hCAFEF00D);
        drain("trunc");
        verify("trunc");

        // Empty packets are ignored; unknown command counts one error.
        rx_q.push_back(9'h100);
        rx_q.push_back(9'h100);
        pkt_badcmd(8'h05, 3);
        drain("badcmd");
        verify("badcmd");

        // Out-of-range address for write and read.
        pkt_write(32'h00000100, 32'h12345678);
        pkt_read(32'h80000002);
        drain("oor");
        verify("oor");

        // Randomized mix of packet kinds under random backpressure.
        full_mode = 2;
        for (int p = 0; p < 60; p++) begin
            logic [AW-1:0] a;
            logic [DW-1:0] d;
            a = ($urandom_range(0, 7) == 0) ? AW'($urandom) | AW'(NREG) : AW'($urandom_range(0, NREG - 1));
            d = DW'($urandom);
            case ($urandom_range(0, 6))
                0, 1:    pkt_write(a, d);
                2, 3:    pkt_read(a);
                4:       pkt_trunc(a, d, $urandom_range(1, 7), 1'($urandom_range(0, 1)));
                5:       pkt_badtail(a, d, 1'($urandom_range(0, 1)));
                default: begin
                    if ($urandom_range(0, 1) == 1) rx_q.push_back(9'h101);
                    else pkt_badcmd(8'($urandom_range(3, 255)), $urandom_range(0, 4));
                end
            endcase
        end
        drain("rand");
        verify("rand");
        full_mode = 0;

        // Error counter saturates at 255 and the controller keeps working.
        for (int p = 0; p < 260; p++) pkt_badcmd(8'hFF, 0);
        pkt_write(32'd3, 32'hA5A55A5A);
        drain("sat");
        verify("sat");

        // Reset in the middle of a reply.
        pkt_read(32'd3);
        for (int i = 0; i < 200 && tx_got.size() < 2; i++) step();
        chk_eq("mid_reply_reached", 64'(tx_got.size()), 64'd2);
        rst_drv = 1'b0;
        step();
        rst_drv = 1'b1;
        step();
        chk_eq("rst_reply_tx_wr", 64'(last_tx_wr), 64'd0);
        tx_got.delete();
        tx_exp.delete();
        for (int k = 0; k < NREG; k++) mem_m[k] = '0;
        err_m = 0;
        int_m = int_seen;
        last_addr_m = '0;
        repeat (4) step();
        verify("rst_reply");

        // Still operational after the reset.
        pkt_write(32'd9, 32'h0BADC0DE);
        pkt_read(32'd9);
        drain("post_rst");
        verify("post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cfg_pkt_ctrl.md
CFG_PKT_CTRL -- requirements
Module: cfg_pkt_ctrl

Interface
REQ-001 Parameter DW, default 32, register data width in bits; SHALL be a multiple of 8.
REQ-002 Parameter AW, default 32, configuration address width in bits; SHALL be a multiple of 8.
REQ-003 Parameter NREG, default 16, number of DW-wide configuration registers; SHALL be a power of 2 and ≥2.
REQ-004 Ports SHALL be:
- clk  in  1  single clock, all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- rx_empty_i  in  1  inbound N-char FIFO empty.
- rx_data_i  in  9  first-word-fall-through head: [8]=control flag; control with [0]=0 is EOP, [0]=1 is EEP.
- rx_rd_o  out  1  pop inbound FIFO this cycle.
- tx_full_i  in  1  outbound N-char FIFO full.
- tx_data_o  out  9  reply N-char, same encoding as rx_data_i.
- tx_wr_o  out  1  push tx_data_o this cycle.
- cfg_data_o  out  DW  register selected by cfg_addr_i, combinational.
- cfg_int_o  out  1  one-cycle pulse after each committed write.
- cfg_wrbusy_o  out  1  write packet in progress.
- cfg_int_addr  out  AW  address of last committed write.
- cfg_addr_i  in  AW  user read-back address.
- err_cnt_o  out  8  count of discarded packets, saturating at 255.

Function
REQ-005 Packet format SHALL be: command byte (0x01 write, 0x02 read), AW/8 address bytes MSB first, for write DW/8 data bytes MSB first, then EOP.
REQ-006 rx_rd_o SHALL be high in every cycle the FSM accepts a character and rx_empty_i=0; never while rx_empty_i=1 or in REPLY/EXEC.
REQ-007 FSM states SHALL be IDLE, ADDR, DATA, TAIL, EXEC, REPLY, DISCARD.
REQ-008 IDLE: EOP/EEP consumed and ignored (empty packet, no error); 0x01 or 0x02 → ADDR; any other data byte → DISCARD.
REQ-009 ADDR: shifts in AW/8 bytes; after last → DATA (write) or TAIL (read).
REQ-010 DATA: shifts in DW/8 bytes; after last → TAIL.
REQ-011 TAIL: EOP → EXEC; data byte → DISCARD.
REQ-012 Any EOP/EEP in ADDR or DATA, or EEP in TAIL, SHALL be consumed, increment err_cnt_o, return to IDLE, no register change.
REQ-013 DISCARD: consumes characters up to and including next EOP/EEP, then increments err_cnt_o and returns to IDLE.
REQ-014 Address index SHALL be addr[log2(NREG)-1:0]; any nonzero higher bit makes the packet an error at EXEC (err_cnt_o+1, no write, no reply).
REQ-015 EXEC write: register and cfg_int_addr update at the EXEC edge; cfg_int_o high exactly the next cycle; → IDLE.
REQ-016 EXEC read: latch register into reply shifter; → REPLY.
REQ-017 REPLY: emits 0x82, DW/8 data bytes MSB first, then EOP (9'h100); tx_wr_o high only when tx_full_i=0; characters never dropped or repeated; after EOP → IDLE.
REQ-018 cfg_wrbusy_o SHALL be high from the cycle after a 0x01 command is consumed until EXEC completes or the packet is discarded.
REQ-019 A write to register k and a simultaneous cfg_addr_i=k SHALL show the old value until the edge that commits.
REQ-020 Characters of one packet SHALL never be interleaved with another; the next packet starts with the first character after EOP/EEP.

Reset
REQ-021 On rst_n=0 at a clock edge: FSM→IDLE, all registers 0, cfg_int_addr 0, err_cnt_o 0, rx_rd_o/tx_wr_o/cfg_int_o/cfg_wrbusy_o 0, tx_data_o 0.
REQ-022 Reset mid-packet or mid-reply SHALL abandon it without any register write; remaining inbound characters are then parsed as a new packet.

Structure
REQ-023 Command codes, reply code 0x82, EOP/EEP encodings and FSM state enum SHALL live in shared package spw_cfg_pkg.
REQ-024 Register array with write port and combinational read ports SHALL be sub-module cfg_regfile.

Verification
REQ-025 Write 01 00 00 00 03 DE AD BE EF EOP → reg3=0xDEADBEEF, cfg_int_o one pulse, cfg_int_addr=0x3, err_cnt_o=0.
REQ-026 Then read 02 00 00 00 03 EOP with tx_full_i toggling every cycle → tx sequence 0x082,0xDE,0xAD,0xBE,0xEF,0x100 exactly once each.
REQ-027 Write truncated by EEP after 2 data bytes → no register change, err_cnt_o=1, cfg_wrbusy_o drops, following packet processed normally.
REQ-028 EOP,EOP then command 0x05 with 3 bytes and EOP → empty packets ignored, err_cnt_o+1 once.
REQ-029 Write to address 0x00000100 → no write, no interrupt, err_cnt_o+1.
REQ-030 rst_n=0 during REPLY after 2 bytes → tx_wr_o 0 next cycle, all registers 0, FSM IDLE.
